ram_dp_param: RTL and testbench
===============================

Name: ram_dp_param

Overview:
Parametrised successor to the fixed 4096-deep dual-port RAM. It provides:
- independent synchronous write and read ports with per-byte write enables;
- selectable read latency and selectable read-during-write policy;
- an optional post-reset clear sweep;
- a read-valid strobe.

It sits behind the RAM interface as the DUV for the dual-port RAM environment. It also serves as a reusable on-chip buffer.

Parameters:
DW, 32, data width in bits; must be a multiple of 8
DEPTH, 4096, number of words; need not be a power of two
AW, $clog2(DEPTH), address width (derived, do not override)
RD_LATENCY, 1, read latency in cycles from the read sample edge to data_out; legal values 1 or 2
RDW_MODE, 1, same-address read-during-write policy: 0 = old data, 1 = new data (byte-merged)
CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting traffic

Ports:
clk  input  1  single clock, all logic on posedge
resetn  input  1  asynchronous active-low reset
write  input  1  write strobe
wr_address  input  AW  write address
data_in  input  DW  write data
wr_be  input  DW/8  byte enables; bit i covers data_in[8i+7:8i]
read  input  1  read strobe
rd_address  input  AW  read address
data_out  output  DW  read data
rd_valid  output  1  one-cycle pulse, aligned with new data_out
init_done  output  1  high once the block accepts traffic
par_inject  input  1  parity error injection (used only with RAM_PARITY_EN)
rd_parity_err  output  1  parity mismatch, qualified by rd_valid

Behaviour:
- Reset (resetn=0, asynchronous):
  - data_out=0, rd_valid=0, init_done=0, rd_parity_err=0;
  - read pipeline flushed; FSM forced to S_INIT;
  - memory contents are not reset directly.
- FSM states:
  - S_INIT: a clear counter clr_addr runs from 0 to DEPTH-1, writing all-zero data (and correct parity) one word per cycle. Transition to S_RUN on the edge after clr_addr=DEPTH-1. With CLEAR_ON_RESET=1, init_done rises DEPTH+1 cycles after resetn deasserts.
  - CLEAR_ON_RESET=0: S_INIT lasts one cycle; memory content is X/undefined.
  - S_RUN: terminal state until the next reset.
- While init_done=0:
  - write and read are ignored;
  - rd_valid stays 0.
- Write (S_RUN): on the posedge with write=1, bytes with wr_be[i]=1 are updated; other bytes are retained. wr_be=0 is a no-op.
- Read (S_RUN): read=1 sampled at edge N.
  - RD_LATENCY=1: data_out and rd_valid update at edge N.
  - RD_LATENCY=2: data_out and rd_valid update at edge N+1.
  - Back-to-back reads give one result per cycle.
  - data_out holds its last value when no read is active; rd_valid pulses exactly one cycle per read.
- Same-address write and read in the same cycle:
  - RDW_MODE=0 returns pre-write data;
  - RDW_MODE=1 returns the stored word with enabled bytes replaced by data_in.
- Different addresses in the same cycle: fully independent.
- Out of range (address >= DEPTH, non-power-of-two DEPTH only):
  - write is dropped;
  - read returns 0 with rd_valid=1.
- Reset mid-operation: in-flight reads are discarded (no rd_valid). With CLEAR_ON_RESET=1, the clear sweep restarts from address 0.

Optional Feature:
RAM_PARITY_EN:
- Defined:
  - each byte is stored with an even-parity bit;
  - par_inject=1 during a write inverts the stored parity bit of byte 0;
  - on read, parity is recomputed per byte, and rd_parity_err=1 in the rd_valid cycle if any byte mismatches;
  - the clear sweep writes correct parity.
- Undefined: no parity storage, rd_parity_err tied 0, par_inject ignored.

Decomposition:
- Package ram_dp_pkg holds:
  - typedef enum {S_INIT,S_RUN} ram_dp_state_e;
  - localparams RDW_OLD=0 and RDW_NEW=1;
  - function byte_parity() for even parity of an 8-bit value;
  - function merge_bytes(old, new, be).
- One sub-module, ram_dp_init_ctrl, contains the FSM, clr_addr counter and init_done.
- Memory array, write merge and read pipeline stay in ram_dp_param.

Test Plan:
- Clear sweep (DEPTH=4096, CLEAR_ON_RESET=1): release resetn -> init_done rises at edge 4097. read addr 0x000, 0x7FF and 0xFFF -> data_out=0x00000000 with rd_valid.
- Byte enables: write 0xAABBCCDD be=4'hF to addr 5, then 0x11223344 be=4'b0101 to addr 5 -> read addr 5 returns 0xAA22CC44.
- Collision at addr 9 (old 0x0, write 0xDEADBEEF be=4'hF, read same cycle) -> RDW_MODE=0 returns 0x00000000; RDW_MODE=1 returns 0xDEADBEEF.
- Latency: RD_LATENCY=2, reads issued to addrs 1,2,3 on consecutive edges (data 0x1,0x2,0x3) -> rd_valid high for 3 cycles starting 2 edges after the first read; data 0x1, 0x2, 0x3 in order.
- Traffic during init and reset mid-read: a write to addr 0 during S_INIT is ignored (reads 0 later). Asserting resetn=0 one cycle after a read -> no rd_valid, data_out=0.
- RAM_PARITY_EN: write 0x000000FF with par_inject=1 to addr 7 -> read addr 7 gives rd_parity_err=1 with rd_valid. A clean write and read of the same address -> rd_parity_err=0.

Source files
------------

// File: rtl/ram_dp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_dp_pkg
// Brief    : Shared types and helpers for the parametrised dual-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
package ram_dp_pkg;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } ram_dp_state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

    function automatic logic [7:0] merge_bytes(input logic [7:0] old_b,
                                               input logic [7:0] new_b,
                                               input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_dp_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_dp_init_ctrl
// Brief    : Post-reset clear sweep FSM; raises init_done once traffic is allowed.
// Revision : 1.0 - initial release
// ============================================================================
module ram_dp_init_ctrl
    import ram_dp_pkg::*;
#(
    parameter int DEPTH          = 4096,
    parameter int AW             = $clog2(DEPTH),
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          resetn,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          init_done
);

    // One extra count value gives the idle cycle between the last clear and S_RUN.
    localparam int              c_CW   = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DEPTH);

    ram_dp_state_e   r_state;
    ram_dp_state_e   w_state_nxt;
    logic [c_CW-1:0] r_clr_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_INIT;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_INIT && r_clr_cnt != c_LAST) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  if (CLEAR_ON_RESET == 0 || r_clr_cnt == c_LAST) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        clr_we    = (r_state == S_INIT) && (CLEAR_ON_RESET != 0) && (r_clr_cnt != c_LAST);
        clr_addr  = r_clr_cnt[AW-1:0];
        init_done = (r_state == S_RUN);
    end

endmodule
`default_nettype wire

// File: rtl/ram_dp_param.sv
`default_nettype none
// ============================================================================
// Module   : ram_dp_param
// Brief    : Parametrised dual-port RAM with byte enables, 1/2-cycle read
//            latency, read-during-write policy and optional clear sweep.
//            Optional byte parity is enabled by defining RAM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ram_dp_param
    import ram_dp_pkg::*;
#(
    parameter int DW             = 32,
    parameter int DEPTH          = 4096,
    parameter int AW             = $clog2(DEPTH),
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            write,
    input  logic [AW-1:0]   wr_address,
    input  logic [DW-1:0]   data_in,
    input  logic [DW/8-1:0] wr_be,
    input  logic            read,
    input  logic [AW-1:0]   rd_address,
    output logic [DW-1:0]   data_out,
    output logic            rd_valid,
    output logic            init_done,
    input  logic            par_inject,
    output logic            rd_parity_err
);

    localparam int            c_NB    = DW / 8;
    localparam logic [AW:0]   c_DEPTH = (AW + 1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];

    logic          w_clr_we;
    logic [AW-1:0] w_clr_addr;
    logic          w_init_done;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_rd_inr;
    logic          w_coll;
    logic [DW-1:0] w_rd_word;
    logic [DW-1:0] w_rd_data;
    logic          w_rd_err;

    logic [DW-1:0] r_s1_data;
    logic          r_s1_valid;
    logic          r_s1_err;

    ram_dp_init_ctrl #(
        .DEPTH          (DEPTH),
        .AW             (AW),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_init_ctrl (
        .clk       (clk),
        .resetn    (resetn),
        .clr_we    (w_clr_we),
        .clr_addr  (w_clr_addr),
        .init_done (w_init_done)
    );

    assign init_done = w_init_done;
    assign w_wr_en   = w_init_done & write & ({1'b0, wr_address} < c_DEPTH);
    assign w_rd_en   = w_init_done & read;
    assign w_rd_inr  = ({1'b0, rd_address} < c_DEPTH);
    assign w_coll    = (RDW_MODE == RDW_NEW) && w_wr_en && (wr_address == rd_address);

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < c_NB; i++) begin
                if (wr_be[i]) r_mem[wr_address][8*i +: 8] <= data_in[8*i +: 8];
            end
        end
    end

    // Collision bypass only in new-data mode; out-of-range reads return zero.
    always_comb begin
        w_rd_word = r_mem[rd_address];
        w_rd_data = '0;
        for (int i = 0; i < c_NB; i++) begin
            w_rd_data[8*i +: 8] = merge_bytes(w_rd_word[8*i +: 8], data_in[8*i +: 8],
                                              w_coll & wr_be[i]);
        end
        if (!w_rd_inr) w_rd_data = '0;
    end

`ifdef RAM_PARITY_EN
    logic [c_NB-1:0] r_par [DEPTH];
    logic [c_NB-1:0] w_wr_par;
    logic [c_NB-1:0] w_rd_par;

    always_comb begin
        w_wr_par = '0;
        for (int i = 0; i < c_NB; i++) w_wr_par[i] = byte_parity(data_in[8*i +: 8]);
        w_wr_par[0] = w_wr_par[0] ^ par_inject;
    end

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_par[w_clr_addr] <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < c_NB; i++) begin
                if (wr_be[i]) r_par[wr_address][i] <= w_wr_par[i];
            end
        end
    end

    always_comb begin
        w_rd_par = r_par[rd_address];
        w_rd_err = 1'b0;
        for (int i = 0; i < c_NB; i++) begin
            if (w_coll && wr_be[i]) w_rd_par[i] = w_wr_par[i];
            w_rd_err = w_rd_err | (byte_parity(w_rd_data[8*i +: 8]) ^ w_rd_par[i]);
        end
        w_rd_err = w_rd_err & w_rd_inr;
    end
`else
    logic w_unused_par;
    assign w_unused_par = par_inject;
    assign w_rd_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
        end else begin
            r_s1_valid <= w_rd_en;
            if (w_rd_en) begin
                r_s1_data <= w_rd_data;
                r_s1_err  <= w_rd_err;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DW-1:0] r_s2_data;
            logic          r_s2_valid;
            logic          r_s2_err;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_s2_data  <= '0;
                    r_s2_valid <= 1'b0;
                    r_s2_err   <= 1'b0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                        r_s2_err  <= r_s1_err;
                    end
                end
            end

            assign data_out      = r_s2_data;
            assign rd_valid      = r_s2_valid;
            assign rd_parity_err = r_s2_valid & r_s2_err;
        end else begin : g_lat1
            assign data_out      = r_s1_data;
            assign rd_valid      = r_s1_valid;
            assign rd_parity_err = r_s1_valid & r_s1_err;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ram_dp_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_dp_param
// Brief    : Directed bench: A = defaults (4096, lat 1, new data);
//            B = 100 deep, lat 2, old data, sharing the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ram_dp_param;

    logic        clk = 1'b0;
    logic        resetn;
    logic        write, read, par_inject;
    logic [11:0] wr_address, rd_address;
    logic [6:0]  wr_address_b, rd_address_b;
    logic [31:0] data_in;
    logic [3:0]  wr_be;
    logic [31:0] data_out_a, data_out_b;
    logic        rd_valid_a, rd_valid_b, init_done_a, init_done_b, err_a, err_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign wr_address_b = wr_address[6:0];
    assign rd_address_b = rd_address[6:0];

    ram_dp_param u_dut_a (
        .clk(clk), .resetn(resetn), .write(write), .wr_address(wr_address),
        .data_in(data_in), .wr_be(wr_be), .read(read), .rd_address(rd_address),
        .data_out(data_out_a), .rd_valid(rd_valid_a), .init_done(init_done_a),
        .par_inject(par_inject), .rd_parity_err(err_a)
    );

    ram_dp_param #(.DEPTH(100), .RD_LATENCY(2), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_dut_b (
        .clk(clk), .resetn(resetn), .write(write), .wr_address(wr_address_b),
        .data_in(data_in), .wr_be(wr_be), .read(read), .rd_address(rd_address_b),
        .data_out(data_out_b), .rd_valid(rd_valid_b), .init_done(init_done_b),
        .par_inject(par_inject), .rd_parity_err(err_b)
    );

    typedef struct {
        logic        wr;
        logic [11:0] wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        rd;
        logic [11:0] ra;
        logic        va;
        logic [31:0] da;
        logic        vb;
        logic [31:0] db;
    } vec_t;

    vec_t vt [31];

    function automatic vec_t mk(logic wr, logic [11:0] wa, logic [31:0] wd, logic [3:0] be,
                                logic rd, logic [11:0] ra, logic va, logic [31:0] da,
                                logic vb, logic [31:0] db);
        vec_t v;
        v.wr = wr; v.wa = wa; v.wd = wd; v.be = be; v.rd = rd; v.ra = ra;
        v.va = va; v.da = da; v.vb = vb; v.db = db;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [11:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic rd, input logic [11:0] ra,
                         input logic pi);
        write = wr; wr_address = wa; data_in = wd; wr_be = be;
        read = rd; rd_address = ra; par_inject = pi;
    endtask

    // Counts edges after reset release; pokes a write+read at addr 0 mid-sweep.
    task automatic wait_init(output int ea, output int eb, output logic seen);
        ea = 0; eb = 0; seen = 1'b0;
        for (int e = 1; e <= 4200 && ea == 0; e++) begin
            @(posedge clk); #1;
            if (rd_valid_a || rd_valid_b) seen = 1'b1;
            if (init_done_b && eb == 0) eb = e;
            if (init_done_a && ea == 0) ea = e;
            if (e == 9)  drive(1'b1, 12'h000, 32'h12345678, 4'hF, 1'b1, 12'h000, 1'b0);
            if (e == 10) drive(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 12'h000, 1'b0);
        end
    endtask

    int   ea, eb;
    logic seen;

    initial begin
        vt[0]  = mk(1, 12'h005, 32'hAABBCCDD, 4'hF, 0, 12'h000, 0, 32'h0,        0, 32'h0);
        vt[1]  = mk(1, 12'h005, 32'h11223344, 4'h5, 0, 12'h000, 0, 32'h0,        0, 32'h0);
        vt[2]  = mk(0, 12'h000, 32'h0,        4'h0, 1, 12'h005, 1, 32'hAA22CC44, 0, 32'h0);
        vt[3]  = mk(0, 12'h000, 32'h0,        4'h0, 1, 12'h000, 1, 32'h0,        1, 32'hAA22CC44);
        vt[4]  = mk(1, 12'h009, 32'hDEADBEEF, 4'hF, 1, 12'h009, 1, 32'hDEADBEEF, 1, 32'h0);
        vt[5]  = mk(0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 32'hDEADBEEF, 1, 32'h0);
        vt[6]  = mk(0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 32'hDEADBEEF, 0, 32'h0);
        vt[7]  = mk(0, 12'h000, 32'h0,        4'h0, 1, 12'h009, 1, 32'hDEADBEEF, 0, 32'h0);
        vt[8]  = mk(0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF);
        vt[9]  = mk(1, 12'h001, 32'h1,        4'hF, 0, 12'h000, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
        vt[10] = mk(1, 12'h002, 32'h2,        4'hF, 0, 12'h000, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
        vt[11] = mk(1, 12'h003, 32'h3,        4'hF, 0, 12'h000, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
        vt[12] = mk(0, 12'h000, 32'h0,        4'h0, 1, 12'h001, 1, 32'h1,        0, 32'hDEADBEEF);
        vt[13] = mk(0, 12'h000, 32'h0,        4'h0, 1, 12'h002, 1, 32'h2,        1, 32'h1);
        vt[14] = mk(0, 12'h000, 32'h0,        4'h0, 1, 12'h003, 1, 32'h3,        1, 32'h2);
        vt[15] = mk(0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 32'h3,        1, 32'h3);
        vt[16] = mk(0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 32'h3,        0, 32'h3);
        vt[17] = mk(1, 12'h001, 32'hFFFFFFFF, 4'h0, 0, 12'h000, 0, 32'h3,        0, 32'h3);
        vt[18] = mk(0, 12'h000, 32'h0,        4'h0, 1, 12'h001, 1, 32'h1,        0, 32'h3);
        vt[19] = mk(0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 32'h1,        1, 32'h1);
        vt[20] = mk(1, 12'h002, 32'hAB00CD00, 4'hA, 1, 12'h002, 1, 32'hAB00CD02, 0, 32'h1);
        vt[21] = mk(0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 32'hAB00CD02, 1, 32'h2);
        vt[22] = mk(1, 12'h004, 32'h44444444, 4'hF, 1, 12'h002, 1, 32'hAB00CD02, 0, 32'h2);
        vt[23] = mk(0, 12'h000, 32'h0,        4'h0, 1, 12'h004, 1, 32'h44444444, 1, 32'hAB00CD02);
        vt[24] = mk(0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 32'h44444444, 1, 32'h44444444);
        vt[25] = mk(1, 12'h064, 32'h99999999, 4'hF, 0, 12'h000, 0, 32'h44444444, 0, 32'h44444444);
        vt[26] = mk(0, 12'h000, 32'h0,        4'h0, 1, 12'h064, 1, 32'h99999999, 0, 32'h44444444);
        vt[27] = mk(0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 32'h99999999, 1, 32'h0);
        vt[28] = mk(0, 12'h000, 32'h0,        4'h0, 1, 12'h7FF, 1, 32'h0,        0, 32'h0);
        vt[29] = mk(0, 12'h000, 32'h0,        4'h0, 1, 12'hFFF, 1, 32'h0,        1, 32'h0);
        vt[30] = mk(0, 12'h000, 32'h0,        4'h0, 0, 12'h000, 0, 32'h0,        1, 32'h0);

        drive(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 12'h000, 1'b0);
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #10;
        chk("rst_dout_a", data_out_a, 32'h0);
        chk("rst_valid_a", {31'b0, rd_valid_a}, 32'h0);
        chk("rst_init_a", {31'b0, init_done_a}, 32'h0);
        chk("rst_perr_a", {31'b0, err_a}, 32'h0);
        chk("rst_init_b", {31'b0, init_done_b}, 32'h0);

        @(negedge clk) resetn = 1'b1;
        wait_init(ea, eb, seen);
        chk("init_edge_a", ea, 32'd4097);
        chk("init_edge_b", eb, 32'd101);
        chk("init_no_valid", {31'b0, seen}, 32'h0);

        for (int i = 0; i < 31; i++) begin
            drive(vt[i].wr, vt[i].wa, vt[i].wd, vt[i].be, vt[i].rd, vt[i].ra, 1'b0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid_a", i), {31'b0, rd_valid_a}, {31'b0, vt[i].va});
            chk($sformatf("v%0d_data_a", i), data_out_a, vt[i].da);
            chk($sformatf("v%0d_valid_b", i), {31'b0, rd_valid_b}, {31'b0, vt[i].vb});
            chk($sformatf("v%0d_data_b", i), data_out_b, vt[i].db);
            chk($sformatf("v%0d_perr", i), {30'b0, err_a, err_b}, 32'h0);
        end

        // Reset one cycle after a read: B's in-flight result must vanish.
        drive(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 12'h005, 1'b0);
        @(posedge clk); #1;
        chk("mid_valid_a", {31'b0, rd_valid_a}, 32'h1);
        chk("mid_data_a", data_out_a, 32'hAA22CC44);
        drive(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 12'h000, 1'b0);
        @(negedge clk) resetn = 1'b0;
        #1;
        chk("mid_rst_dout_a", data_out_a, 32'h0);
        chk("mid_rst_valid_a", {31'b0, rd_valid_a}, 32'h0);
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (rd_valid_b) seen = 1'b1;
        end
        chk("mid_rst_valid_b", {31'b0, seen}, 32'h0);
        chk("mid_rst_dout_b", data_out_b, 32'h0);

        @(negedge clk) resetn = 1'b1;
        wait_init(ea, eb, seen);
        chk("reinit_edge_a", ea, 32'd4097);
        chk("reinit_no_valid", {31'b0, seen}, 32'h0);
        drive(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 12'h005, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 12'h000, 1'b0);
        chk("reclr_valid_a", {31'b0, rd_valid_a}, 32'h1);
        chk("reclr_data_a", data_out_a, 32'h0);
        @(posedge clk); #1;
        chk("reclr_valid_b", {31'b0, rd_valid_b}, 32'h1);
        chk("reclr_data_b", data_out_b, 32'h0);

`ifdef RAM_PARITY_EN
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 12'h007, 32'h000000FF, 4'hF, 1'b0, 12'h000, (k == 0));
            @(posedge clk); #1;
            drive(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 12'h007, 1'b0);
            @(posedge clk); #1;
            drive(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 12'h000, 1'b0);
            chk($sformatf("par%0d_a", k), {30'b0, rd_valid_a, err_a}, (k == 0) ? 32'h3 : 32'h2);
            @(posedge clk); #1;
            chk($sformatf("par%0d_b", k), {30'b0, rd_valid_b, err_b}, (k == 0) ? 32'h3 : 32'h2);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
